// File: rtl/valu_wb_queue_pkg.sv
// Shared vALU constants: lane widths, lane latency and writeback entry layout.
package valu_wb_queue_pkg;

    localparam int VALU_DATA_WIDTH   = 64;
    localparam int VALU_ADDR_WIDTH   = 32;
    localparam int VALU_LANE_LATENCY = 6;

    // Entry layout, LSB first: data, addr, w_reg, sca (MSB).
    localparam int ENTRY_DATA_LSB = 0;
    localparam int ENTRY_ADDR_LSB = ENTRY_DATA_LSB + VALU_DATA_WIDTH;
    localparam int ENTRY_WREG_BIT = ENTRY_ADDR_LSB + VALU_ADDR_WIDTH;
    localparam int ENTRY_SCA_BIT  = ENTRY_WREG_BIT + 1;
    localparam int ENTRY_WIDTH    = ENTRY_SCA_BIT + 1;

endpackage

// File: rtl/valu_wb_queue_sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; the head entry is held in a register
// so the read side has no combinational path from the write side.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;

    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [CW-1:0]    count_next_s;
    logic [AW-1:0]    rd_next_s;
    logic [AW-1:0]    wr_next_s;
    logic [WIDTH-1:0] head_next_s;

    // Accept/advance decisions and the next head value.
    always_comb begin
        full_s       = (count_r == DEPTH_C);
        pop_s        = rd_en & valid_r;
        // A push into a full queue is only taken when a pop frees the slot.
        push_s       = wr_en & (~full_s | pop_s);
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        rd_next_s = pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
        wr_next_s = push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
        if (count_next_s == CW'(0)) begin
            head_next_s = '0;
        end else if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = wr_data;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Entry storage; contents are only observed once written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
            valid_r  <= (count_next_s != CW'(0));
        end
    end

    assign rd_data    = head_r;
    assign rd_valid   = valid_r;
    assign full       = full_s;
    assign count      = count_r;
    assign count_next = count_next_s;

endmodule

// File: rtl/valu_wb_queue.sv
// Writeback queue between the and/or/xor vALU lane and the VRF write port,
// with an early issue stall sized to cover results still in the lane.
module valu_wb_queue
    import valu_wb_queue_pkg::*;
#(
    parameter int DATA_WIDTH  = VALU_DATA_WIDTH,
    parameter int ADDR_WIDTH  = VALU_ADDR_WIDTH,
    parameter int DEPTH       = 16,
    parameter int STALL_SLACK = VALU_LANE_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_vec,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic                    in_valid,
    input  logic                    in_w_reg,
    input  logic                    in_sca,
    output logic [DATA_WIDTH-1:0]   wb_data,
    output logic [ADDR_WIDTH-1:0]   wb_addr,
    output logic                    wb_w_reg,
    output logic                    wb_sca,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic                    issue_stall,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int ADDR_LSB = DATA_WIDTH;
    localparam int WREG_BIT = ADDR_LSB + ADDR_WIDTH;
    localparam int SCA_BIT  = WREG_BIT + 1;
    localparam int EW       = SCA_BIT + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] SLACK_C = CW'(STALL_SLACK);

    logic [EW-1:0] entry_s;
    logic [EW-1:0] head_s;
    logic          head_valid_s;
    logic          full_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_next_s;
    logic          pop_s;
    logic          overflow_r;
    logic          stall_r;

    assign entry_s = {in_sca, in_w_reg, in_addr, in_vec};
    assign pop_s   = head_valid_s & wb_ready;

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (in_valid),
        .wr_data    (entry_s),
        .rd_en      (wb_ready),
        .rd_data    (head_s),
        .rd_valid   (head_valid_s),
        .full       (full_s),
        .count      (count_s),
        .count_next (count_next_s)
    );

    // Sticky drop flag; the lane cannot be back-pressured so a full push is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else if (in_valid && full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end
    end

    // Stall registered from next occupancy so it tracks the registered count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r <= 1'b0;
        end else begin
            stall_r <= ((DEPTH_C - count_next_s) <= SLACK_C);
        end
    end

    assign wb_data     = head_s[DATA_WIDTH-1:0];
    assign wb_addr     = head_s[WREG_BIT-1:ADDR_LSB];
    assign wb_w_reg    = head_s[WREG_BIT];
    assign wb_sca      = head_s[SCA_BIT];
    assign wb_valid    = head_valid_s;
    assign count       = count_s;
    assign issue_stall = stall_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_valu_wb_queue.sv
// Directed bench for valu_wb_queue with immediate-assertion checks.
module tb_valu_wb_queue;

    logic        clk;
    logic        rst;
    logic [63:0] in_vec;
    logic [31:0] in_addr;
    logic        in_valid;
    logic        in_w_reg;
    logic        in_sca;
    logic [63:0] wb_data;
    logic [31:0] wb_addr;
    logic        wb_w_reg;
    logic        wb_sca;
    logic        wb_valid;
    logic        wb_ready;
    logic        issue_stall;
    logic [4:0]  count;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    valu_wb_queue dut (
        .clk         (clk),
        .rst         (rst),
        .in_vec      (in_vec),
        .in_addr     (in_addr),
        .in_valid    (in_valid),
        .in_w_reg    (in_w_reg),
        .in_sca      (in_sca),
        .wb_data     (wb_data),
        .wb_addr     (wb_addr),
        .wb_w_reg    (wb_w_reg),
        .wb_sca      (wb_sca),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .issue_stall (issue_stall),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] v, input logic [31:0] a);
        in_valid = 1'b1;
        in_vec   = v;
        in_addr  = a;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int exp_next;
        int pushed;
        rst = 1'b0;
        in_vec = 64'd0; in_addr = 32'd0; in_valid = 1'b0;
        in_w_reg = 1'b0; in_sca = 1'b0; wb_ready = 1'b0;
        #12;
        check("reset_valid", wb_valid, 1'b0);
        check("reset_count", count, 5'd0);
        check("reset_stall", issue_stall, 1'b0);
        check("reset_ovf", overflow, 1'b0);
        check("reset_data", wb_data, 64'd0);
        rst = 1'b1;
        tick();

        // Single result
        in_sca = 1'b1;
        push(64'hDEADBEEF_00000001, 32'h40);
        in_sca = 1'b0;
        check("single_valid", wb_valid, 1'b1);
        check("single_data", wb_data, 64'hDEADBEEF_00000001);
        check("single_addr", wb_addr, 32'h40);
        check("single_sca", wb_sca, 1'b1);
        check("single_wreg", wb_w_reg, 1'b0);
        check("single_count", count, 5'd1);
        wb_ready = 1'b1;
        tick();
        check("single_drain_valid", wb_valid, 1'b0);
        check("single_drain_count", count, 5'd0);
        check("single_drain_data", wb_data, 64'd0);

        // Backpressure and fill to 10
        wb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_w_reg = (i == 3);
            push(64'(i + 100), 32'(i));
            check("fill_count", count, 5'(i + 1));
            check("fill_stall", issue_stall, (i + 1) >= 10);
            check("fill_head", wb_addr, 32'd0);
        end
        in_w_reg = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("drain_addr", wb_addr, 32'(i));
            check("drain_data", wb_data, 64'(i + 100));
            check("drain_wreg", wb_w_reg, (i == 3));
            tick();
            check("drain_count", count, 5'(9 - i));
            check("drain_stall", issue_stall, 1'b0);
        end
        check("drain_empty", wb_valid, 1'b0);

        // Full with simultaneous push and pop
        wb_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(64'(i), 32'(32'h100 + i));
        check("full_count", count, 5'd16);
        check("full_stall", issue_stall, 1'b1);
        wb_ready = 1'b1;
        push(64'hAA, 32'h1AA);
        check("pp_count", count, 5'd16);
        check("pp_ovf", overflow, 1'b0);
        check("pp_head", wb_addr, 32'h101);
        for (int i = 1; i < 16; i++) begin
            check("pp_drain", wb_addr, 32'(32'h100 + i));
            tick();
        end
        check("pp_last", wb_addr, 32'h1AA);
        check("pp_last_data", wb_data, 64'hAA);
        tick();
        check("pp_empty", wb_valid, 1'b0);

        // Overflow
        wb_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(64'(i), 32'(32'h200 + i));
        push(64'hFF, 32'hFF);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_count", count, 5'd16);
        check("ovf_head", wb_addr, 32'h200);
        wb_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain", wb_addr, 32'(32'h200 + i));
            tick();
        end
        check("ovf_empty", wb_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // Async reset mid-operation
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(64'(i), 32'(32'h300 + i));
        check("ar_pre_count", count, 5'd5);
        check("ar_pre_valid", wb_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", wb_valid, 1'b0);
        check("ar_count", count, 5'd0);
        check("ar_ovf", overflow, 1'b0);
        check("ar_stall", issue_stall, 1'b0);
        check("ar_addr", wb_addr, 32'd0);
        #1;
        rst = 1'b1;
        tick();
        push(64'h7, 32'h7);
        check("ar_push_addr", wb_addr, 32'h7);
        check("ar_push_valid", wb_valid, 1'b1);
        check("ar_push_count", count, 5'd1);
        wb_ready = 1'b1;
        tick();
        check("ar_push_drain", count, 5'd0);

        // Wrap-around stream 1..40 with random ready
        exp_next = 1;
        pushed   = 0;
        for (int c = 0; c < 400 && exp_next <= 40; c++) begin
            wb_ready = 1'($urandom_range(0, 1));
            in_valid = (!issue_stall) && (pushed < 40);
            in_vec   = 64'(pushed + 1);
            in_addr  = 32'(pushed + 1);
            if (wb_valid && wb_ready) begin
                check("wrap_data", wb_data, 64'(exp_next));
                exp_next++;
            end
            if (in_valid) pushed++;
            tick();
        end
        in_valid = 1'b0;
        check("wrap_total", 32'(exp_next), 32'd41);
        check("wrap_empty", wb_valid, 1'b0);
        check("wrap_ovf", overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
